// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the DCPU-16 add/subtract sequencer.
package alu_pkg;

  localparam int WORD_W = 16;

  // Operation codes carried on req_op; any value not listed is illegal.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_ADX = 4'h2,
    OP_SBX = 4'h3,
    OP_IFE = 4'h8,
    OP_IFN = 4'h9,
    OP_IFG = 4'hA,
    OP_IFA = 4'hB,
    OP_IFL = 4'hC,
    OP_IFU = 4'hD
  } alu_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: decodes an op code into datapath mode controls and
// evaluates the IF-condition from the datapath compare flags.
// Purely combinational; also intended for the later IFB/IFC logic.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       eq,
  input  logic       lt,
  input  logic       un,
  output logic       cond,
  output logic       sub,
  output logic       x,
  output logic       wr,
  output logic       illegal
);

  // Decode op into controls; IF ops compare b against a with a plain subtract.
  always_comb begin
    cond    = 1'b0;
    sub     = 1'b0;
    x       = 1'b0;
    wr      = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: wr = 1'b1;
      OP_SUB: begin sub = 1'b1; wr = 1'b1; end
      OP_ADX: begin x = 1'b1; wr = 1'b1; end
      OP_SBX: begin sub = 1'b1; x = 1'b1; wr = 1'b1; end
      OP_IFE: begin sub = 1'b1; cond = eq; end
      OP_IFN: begin sub = 1'b1; cond = !eq; end
      OP_IFG: begin sub = 1'b1; cond = !lt && !eq; end
      OP_IFA: begin sub = 1'b1; cond = !un && !eq; end
      OP_IFL: begin sub = 1'b1; cond = lt; end
      OP_IFU: begin sub = 1'b1; cond = un; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_addsub_ctrl.sv
// alu_addsub_ctrl: request/result sequencer around the combinational
// add/sub datapath; owns the architectural EX register.
// Optional feature macro: ALU_PERF_CNT_EN adds the perf_ex_cnt counter output.
module alu_addsub_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [WORD_W-1:0] req_b,
  input  logic [WORD_W-1:0] req_a,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WORD_W-1:0] res_q,
  output logic              res_wr,
  output logic              res_cond,
  output logic              res_illegal,
  output logic [WORD_W-1:0] ex_q,
  input  logic              ex_wr_en,
  input  logic [WORD_W-1:0] ex_wr_data,
  output logic [WORD_W-1:0] dp_b,
  output logic [WORD_W-1:0] dp_a,
  output logic [WORD_W-1:0] dp_exin,
  output logic              dp_sub,
  output logic              dp_x,
  input  logic [WORD_W-1:0] dp_q,
  input  logic [WORD_W-1:0] dp_ex,
  input  logic              dp_eq,
  input  logic              dp_lt,
  input  logic              dp_un
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_ex_cnt
`endif
);

  alu_state_t        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] ex_d;
  logic              res_valid_q, res_valid_d;
  logic [WORD_W-1:0] res_data_q, res_data_d;
  logic              res_wr_q, res_wr_d;
  logic              res_cond_q, res_cond_d;
  logic              res_illegal_q, res_illegal_d;

  logic dec_cond, dec_sub, dec_x, dec_wr, dec_illegal;
  logic in_exec;
  logic req_fire;

  assign in_exec = (state_q == ST_EXEC);

  alu_cond_eval u_cond_eval (
    .op      (op_q),
    .eq      (dp_eq),
    .lt      (dp_lt),
    .un      (dp_un),
    .cond    (dec_cond),
    .sub     (dec_sub),
    .x       (dec_x),
    .wr      (dec_wr),
    .illegal (dec_illegal)
  );

  // Accept in IDLE, or in DONE when the result leaves in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      req_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready);
    end
  end

  assign req_fire = req_valid && req_ready;

  // Datapath is only driven during EXEC; otherwise it sees all zeros.
  always_comb begin
    dp_b    = '0;
    dp_a    = '0;
    dp_exin = '0;
    dp_sub  = 1'b0;
    dp_x    = 1'b0;
    if (in_exec) begin
      dp_b    = b_q;
      dp_a    = a_q;
      dp_exin = ex_q;
      dp_sub  = dec_sub;
      dp_x    = dec_x;
    end
  end

  // Next-state: FSM, request capture, result capture and EX update priority.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    b_d           = b_q;
    a_d           = a_q;
    ex_d          = ex_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_wr_d      = res_wr_q;
    res_cond_d    = res_cond_q;
    res_illegal_d = res_illegal_q;

    if (req_fire) begin
      op_d = req_op;
      b_d  = req_b;
      a_d  = req_a;
    end

    // External EX write; overridden below by an arithmetic EXEC update.
    if (ex_wr_en) begin
      ex_d = ex_wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d       = ST_DONE;
        res_valid_d   = 1'b1;
        res_data_d    = dec_wr ? dp_q : '0;
        res_wr_d      = dec_wr;
        res_cond_d    = dec_cond;
        res_illegal_d = dec_illegal;
        if (dec_wr) begin
          ex_d = dp_ex;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = req_fire ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      b_q           <= '0;
      a_q           <= '0;
      ex_q          <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_wr_q      <= 1'b0;
      res_cond_q    <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      b_q           <= b_d;
      a_q           <= a_d;
      ex_q          <= ex_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_wr_q      <= res_wr_d;
      res_cond_q    <= res_cond_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_q       = res_data_q;
  assign res_wr      = res_wr_q;
  assign res_cond    = res_cond_q;
  assign res_illegal = res_illegal_q;

`ifdef ALU_PERF_CNT_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;

  // Count arithmetic ops leaving a non-zero EX, saturating at all-ones.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (in_exec && dec_wr && (dp_ex != '0) && (perf_cnt_q != 16'hFFFF)) begin
      perf_cnt_d = perf_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_ex_cnt = perf_cnt_q;
`endif

endmodule
